// File: rtl/smallcalc_seq_if.sv
// Entry-token handshake between a key source and the calculator sequencer.
// The source owns valid/is_op/data; the sequencer answers with ready.
interface smallcalc_seq_if #(
  parameter int WIDTH = 5
);
  logic             key_valid;
  logic             key_ready;
  logic             key_is_op;
  logic [WIDTH-1:0] key_data;

  modport master (
    output key_valid,
    output key_is_op,
    output key_data,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_is_op,
    input  key_data,
    output key_ready
  );
endinterface

// File: rtl/smallcalc_seq.sv
// Operand/opcode sequencer for the small-calculator ALU: assembles A, op, B
// from a token stream, runs one execute cycle, and holds the result for chaining.
module smallcalc_seq #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  smallcalc_seq_if.slave   key,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [1:0]       alu_c,
  input  logic [WIDTH-1:0] alu_out,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             err,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [2:0] S_A    = 3'd0;
  localparam logic [2:0] S_OP   = 3'd1;
  localparam logic [2:0] S_B    = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_SHOW = 3'd4;

  logic [2:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic             xfer;
  logic             cnt_sat;

  // clear masks ready so a coincident token stays with the source
  assign key.key_ready = (state != S_EXEC) && !clear;
  assign xfer          = key.key_valid && key.key_ready;
  assign cnt_sat       = &op_count;

  assign alu_in1 = a_q;
  assign alu_in2 = b_q;
  assign alu_c   = op_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_A;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      res_zero  <= 1'b0;
      err       <= 1'b0;
      op_count  <= '0;
    end else if (clear) begin
      state     <= S_A;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      res_zero  <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_A: begin
          if (xfer) begin
            if (key.key_is_op) begin
              err <= 1'b1;
            end else begin
              a_q   <= key.key_data;
              state <= S_OP;
            end
          end
        end
        S_OP: begin
          if (xfer) begin
            if (key.key_is_op) begin
              op_q  <= key.key_data[1:0];
              state <= S_B;
            end else begin
              a_q <= key.key_data;
            end
          end
        end
        S_B: begin
          if (xfer) begin
            if (key.key_is_op) begin
              op_q <= key.key_data[1:0];
            end else begin
              b_q   <= key.key_data;
              state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          res_data  <= alu_out;
          res_zero  <= (alu_out == '0);
          res_valid <= 1'b1;
          if (!cnt_sat) op_count <= op_count + 1'b1;
          state <= S_SHOW;
        end
        S_SHOW: begin
          if (xfer) begin
            res_valid <= 1'b0;
            if (key.key_is_op) begin
              // chain: the held result becomes the next A
              a_q   <= res_data;
              op_q  <= key.key_data[1:0];
              state <= S_B;
            end else begin
              a_q   <= key.key_data;
              state <= S_OP;
            end
          end
        end
        default: state <= S_A;
      endcase
    end
  end

endmodule

// File: tb/tb_smallcalc_seq.sv
// Directed bench for smallcalc_seq with a behavioural ALU on the alu_* bus.
module tb_smallcalc_seq;
  localparam int W  = 5;
  localparam int CW = 5;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic [W-1:0]  alu_in1, alu_in2, alu_out, res_data;
  logic [1:0]    alu_c;
  logic          res_valid, res_zero, err;
  logic [CW-1:0] op_count;
  int            errors = 0;
  int            checks = 0;

  smallcalc_seq_if #(.WIDTH(W)) kif ();

  smallcalc_seq #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .key      (kif.slave),
    .alu_in1  (alu_in1),
    .alu_in2  (alu_in2),
    .alu_c    (alu_c),
    .alu_out  (alu_out),
    .res_valid(res_valid),
    .res_data (res_data),
    .res_zero (res_zero),
    .err      (err),
    .op_count (op_count)
  );

  always_comb begin
    alu_out = '0;
    case (alu_c)
      2'b00: alu_out = alu_in1 + alu_in2;
      2'b01: alu_out = alu_in1 - alu_in2;
      2'b10: alu_out = alu_in1 & alu_in2;
      2'b11: alu_out = alu_in1 ^ alu_in2;
      default: alu_out = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one token presented for one edge; returns on the following negedge
  task automatic tok(input logic is_op, input logic [W-1:0] d);
    @(negedge clk);
    kif.key_valid = 1'b1;
    kif.key_is_op = is_op;
    kif.key_data  = d;
    @(negedge clk);
    kif.key_valid = 1'b0;
  endtask

  // A op B, then check the result one cycle after the execute state
  task automatic calc(input string tag, input logic [W-1:0] a, input logic [1:0] op,
                      input logic [W-1:0] b, input logic [W-1:0] exp, input int cnt);
    tok(1'b0, a);
    tok(1'b1, {3'b000, op});
    tok(1'b0, b);
    chk({tag, "_exec_vld"}, res_valid, 0);
    @(negedge clk);
    chk({tag, "_vld"}, res_valid, 1);
    chk({tag, "_data"}, res_data, exp);
    chk({tag, "_zero"}, res_zero, exp == 0);
    chk({tag, "_cnt"}, op_count, cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    kif.key_valid = 1'b0;
    kif.key_is_op = 1'b0;
    kif.key_data  = '0;
    @(negedge clk);
    chk("rst_vld", res_valid, 0);
    chk("rst_in1", alu_in1, 0);
    chk("rst_c", alu_c, 0);
    chk("rst_cnt", op_count, 0);
    chk("rst_err", err, 0);
    chk("rst_rdy", kif.key_ready, 1);
    rst_n = 1'b1;

    // 7 + 5, operand registers visible during execute
    tok(1'b0, 5'd7);
    tok(1'b1, 5'd0);
    tok(1'b0, 5'd5);
    chk("exec_in1", alu_in1, 7);
    chk("exec_in2", alu_in2, 5);
    chk("exec_rdy", kif.key_ready, 0);
    chk("exec_vld", res_valid, 0);
    @(negedge clk);
    chk("add_vld", res_valid, 1);
    chk("add_data", res_data, 12);
    chk("add_zero", res_zero, 0);
    chk("add_cnt", op_count, 1);

    // new calculation from the result state; sub wraps, and yields zero
    calc("sub", 5'd3, 2'b01, 5'd5, 5'd30, 2);
    calc("and", 5'd9, 2'b10, 5'd6, 5'd0, 3);
    calc("add2", 5'd7, 2'b00, 5'd5, 5'd12, 4);

    // chain: opcode after a result reuses it as A
    tok(1'b1, 5'd3);
    chk("chain_in1", alu_in1, 12);
    chk("chain_c", alu_c, 3);
    chk("chain_vld", res_valid, 0);
    tok(1'b0, 5'd15);
    @(negedge clk);
    chk("chain_data", res_data, 3);
    chk("chain_cnt", op_count, 5);

    // clear back to S_A, then out-of-sequence opcode
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_vld", res_valid, 0);
    chk("clr_cnt", op_count, 5);
    tok(1'b1, 5'd1);
    chk("oos_err", err, 1);
    @(negedge clk);
    chk("oos_err_drop", err, 0);
    tok(1'b0, 5'd4);
    tok(1'b0, 5'd6);
    chk("ovr_err", err, 0);
    chk("ovr_in1", alu_in1, 6);
    tok(1'b1, 5'd0);
    tok(1'b1, 5'd2);
    chk("opovr_err", err, 0);
    chk("opovr_c", alu_c, 2);
    tok(1'b0, 5'd3);
    @(negedge clk);
    chk("opovr_data", res_data, 2);
    chk("opovr_cnt", op_count, 6);

    // clear during execute aborts the capture
    tok(1'b0, 5'd2);
    tok(1'b1, 5'd0);
    tok(1'b0, 5'd3);
    clear = 1'b1;
    kif.key_valid = 1'b1;
    kif.key_is_op = 1'b0;
    kif.key_data  = 5'd9;
    #1;
    chk("clrx_rdy", kif.key_ready, 0);
    @(negedge clk);
    clear = 1'b0;
    kif.key_valid = 1'b0;
    chk("clrx_vld", res_valid, 0);
    chk("clrx_cnt", op_count, 6);
    chk("clrx_in1", alu_in1, 0);
    tok(1'b1, 5'd0);
    chk("clrx_sa_err", err, 1);

    // async reset mid-S_B
    tok(1'b0, 5'd5);
    tok(1'b1, 5'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in1", alu_in1, 0);
    chk("arst_c", alu_c, 0);
    chk("arst_cnt", op_count, 0);
    chk("arst_data", res_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // saturation of the completion counter
    for (int i = 0; i < 31; i++) begin
      tok(1'b0, 5'd1);
      tok(1'b1, 5'd0);
      tok(1'b0, 5'd1);
      @(negedge clk);
    end
    chk("sat31", op_count, 31);
    for (int i = 0; i < 2; i++) begin
      tok(1'b0, 5'd1);
      tok(1'b1, 5'd0);
      tok(1'b0, 5'd1);
      @(negedge clk);
    end
    chk("sat_hold", op_count, 31);
    chk("sat_data", res_data, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
